sccb_responder: RTL
===================

// Module: sccb_responder
// PURPOSE
// - SCCB/I2C target (responder): the far end of the camera-config write master. Samples sioc/siod on clk.
// - Decodes the 3-phase write (id, reg, value) and ACKs each byte.
// - Presents each received write as a one-cycle strobe to a local register file.
// - Optionally answers 2-phase reads. Used as the OV7670 stand-in for bench/loopback and as an FPGA-side config port.
// PARAMETERS
// - DEV_ID    8'h42  write address; bit0 ignored on match (8'h42 matches 0x42 write, 0x43 read)
// - SYNC_FF   2      input synchroniser depth for sioc/siod (>=2)
// PORTS
// - clk       in   1  system clock; sioc period must be >= 16 clk
// - reset     in   1  synchronous, active-high
// - sioc      in   1  bus clock from master
// - siod      inout 1 open-drain data; module drives only 1'b0 or 1'bz, never 1'b1
// - wr_valid  out  1  one-clk pulse: wr_reg/wr_data valid
// - wr_reg    out  8  register address of write
// - wr_data   out  8  write value
// - rd_reg    out  8  current register pointer (read lookup address)
// - rd_data   in   8  register file contents at rd_reg, combinational from caller
// - busy      out  1  high from address match until STOP/START/reset
// BEHAVIOUR
// - Reset: siod=z, wr_valid=0, wr_reg=0, wr_data=0, rd_reg=0, busy=0, state=IDLE.
//   - Reset mid-transaction aborts immediately; pointer cleared.
// - Inputs pass SYNC_FF flops; edges are detected against the previous synced sample.
// - Bus conditions:
//   - START: siod fall while sioc high. STOP: siod rise while sioc high.
//   - Both are honoured in every state, including repeated START.
//   - START -> ADDR, bit count 0, siod released. STOP -> IDLE, siod released, busy=0.
// - Data bits: sampled on sioc rising edge, MSB first. Driven bits change only on sioc falling edge.
// - States: IDLE, ADDR, ACK_A, REG, ACK_R, DATA, ACK_D, RD_BYTE, RD_ACK, WAIT_STOP.
//   - ADDR: after 8 bits, match byte[7:1]==DEV_ID[7:1].
//     - Mismatch -> WAIT_STOP; never drives.
//     - Match -> busy=1, ACK_A.
//   - ACK_A/ACK_R/ACK_D: pull siod=0 from the sioc falling edge after bit 8 to the next sioc falling edge, then release.
//   - ACK_A exit: rw=0 -> REG; rw=1 -> RD_BYTE (or WAIT_STOP if reads are compiled out).
//   - REG: 8 bits -> rd_reg<=byte, ACK_R -> DATA.
//   - DATA: 8 bits -> wr_reg<=rd_reg, wr_data<=byte, wr_valid=1 for exactly 1 clk.
//     - wr_valid fires the clk after the synced 8th rising edge.
//     - Then rd_reg<=rd_reg+1 (8-bit wrap FF->00), ACK_D -> DATA (multi-byte burst).
// - Bit counter is 4 bits; resets on START and at every byte boundary.
// - A sioc edge coinciding with a START/STOP detection: the START/STOP wins.
// CONFIGURATION
// - SCCB_READ_EN defined: reads supported.
//   - RD_BYTE: on the falling edge ending ACK_A/RD_ACK, latch rd_data into the shift register.
//   - Then drive siod=0 for 0-bits and z for 1-bits, MSB first, 8 bits.
//   - RD_ACK: siod released and the master bit is sampled on sioc rise.
//     - ACK(0): rd_reg+1, next RD_BYTE.
//     - NACK(1): WAIT_STOP.
// - SCCB_READ_EN undefined: rw=1 address is not ACKed (siod stays z); -> WAIT_STOP; rd_data unused.
// TESTING
// 1. reset, then write id 0x42 reg 0x12 val 0x80 -> single wr_valid with wr_reg=0x12, wr_data=0x80; siod=0 in all 3 ACK slots; busy falls at STOP.
// 2. write id 0x60 reg 0x12 val 0x80 -> siod never driven low, no wr_valid, busy stays 0.
// 3. id 0x42 reg 0xFE then data 0x11,0x22,0x33 -> wr_valid x3: (FE,11),(FF,22),(00,33); rd_reg=0x01 after.
// 4. reset asserted after 5 data bits of reg byte -> siod=z same clk+1, all outputs at reset values; next full write 0x42/0x3A/0x04 succeeds.
// 5. write id 0x42 reg 0x0B (no data), repeated START, id 0x43 with rd_data=0xA5, master NACK, STOP
//    - SCCB_READ_EN: master reads 0xA5, second ACK slot driven 0.
//    - Without: address NACKed, siod z for whole read.
// 6. START immediately followed by STOP, and STOP mid-REG byte -> state IDLE, no wr_valid, no siod drive.

Source files
------------

// File: rtl/sccb_responder_if.sv
// sccb_responder_if
// Local register-file side of the SCCB responder.
//   wr_valid  one-clk strobe, wr_reg/wr_data valid
//   wr_reg    register address of the received write
//   wr_data   received write value
//   rd_reg    current register pointer (read lookup address)
//   rd_data   register contents at rd_reg, combinational from the register file
//   busy      responder has matched its address and owns the transaction
// Modports: slave = responder side, master = register-file side.
interface sccb_responder_if;
  logic       wr_valid;
  logic [7:0] wr_reg;
  logic [7:0] wr_data;
  logic [7:0] rd_reg;
  logic [7:0] rd_data;
  logic       busy;

  modport slave (
    output wr_valid, wr_reg, wr_data, rd_reg, busy,
    input  rd_data
  );

  modport master (
    input  wr_valid, wr_reg, wr_data, rd_reg, busy,
    output rd_data
  );
endinterface

// File: rtl/sccb_responder.sv
// sccb_responder
// SCCB/I2C target: decodes 3-phase writes (id, reg, value), ACKs each byte and
// presents each written value as a one-cycle strobe to a local register file.
// Optional 2-phase reads are compiled in with the macro SCCB_READ_EN.
// Ports:
//   clk    system clock (sioc period must be >= 16 clk)
//   reset  synchronous, active-high
//   sioc   bus clock from the master
//   siod   open-drain data; only ever driven to 0 or released (z)
//   regs   register-file interface (wr_valid/wr_reg/wr_data/rd_reg/rd_data/busy)
module sccb_responder #(
  parameter logic [7:0] DEV_ID  = 8'h42,
  parameter int         SYNC_FF = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sioc,
  inout  wire               siod,
  sccb_responder_if.slave   regs
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_A, REG, ACK_R, DATA, ACK_D, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_FF-1:0] sioc_sync;
  logic [SYNC_FF-1:0] siod_sync;
  logic               sioc_prev;
  logic               siod_prev;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic       rw;
  logic       ack_on;
  logic       drive_low;
  logic       wr_valid;
  logic [7:0] wr_reg;
  logic [7:0] wr_data;
  logic [7:0] rd_reg;
  logic       busy;
`ifdef SCCB_READ_EN
  logic [7:0] tx;
  logic       rd_acked;
`endif

  // Bus inputs are resynchronised; idle level of both lines is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sioc_sync <= '1;
      siod_sync <= '1;
      sioc_prev <= 1'b1;
      siod_prev <= 1'b1;
    end else begin
      sioc_sync <= {sioc_sync[SYNC_FF-2:0], sioc};
      siod_sync <= {siod_sync[SYNC_FF-2:0], siod};
      sioc_prev <= sioc_sync[SYNC_FF-1];
      siod_prev <= siod_sync[SYNC_FF-1];
    end
  end

  logic       sc, sd, rise, fall, start_c, stop_c;
  logic [7:0] next_byte;

  assign sc        = sioc_sync[SYNC_FF-1];
  assign sd        = siod_sync[SYNC_FF-1];
  assign rise      = sc & ~sioc_prev;
  assign fall      = ~sc & sioc_prev;
  // A data line change while sioc is high is a bus condition; it takes
  // priority over a sioc edge seen in the same cycle.
  assign start_c   = sc & siod_prev & ~sd;
  assign stop_c    = sc & ~siod_prev & sd;
  assign next_byte = {shift[6:0], sd};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      rw        <= 1'b0;
      ack_on    <= 1'b0;
      drive_low <= 1'b0;
      wr_valid  <= 1'b0;
      wr_reg    <= '0;
      wr_data   <= '0;
      rd_reg    <= '0;
      busy      <= 1'b0;
`ifdef SCCB_READ_EN
      tx        <= '0;
      rd_acked  <= 1'b0;
`endif
    end else begin
      wr_valid <= 1'b0;
      if (start_c) begin
        state     <= ADDR;
        bit_cnt   <= '0;
        ack_on    <= 1'b0;
        drive_low <= 1'b0;
        busy      <= 1'b0;
      end else if (stop_c) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        ack_on    <= 1'b0;
        drive_low <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ADDR, REG, DATA: begin
            if (rise) begin
              shift <= next_byte;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                case (state)
                  ADDR: begin
                    if (next_byte[7:1] == DEV_ID[7:1]) begin
                      busy <= 1'b1;
                      rw   <= next_byte[0];
`ifdef SCCB_READ_EN
                      state <= ACK_A;
`else
                      // Reads not supported: leave the read address unacknowledged.
                      state <= next_byte[0] ? WAIT_STOP : ACK_A;
`endif
                    end else begin
                      state <= WAIT_STOP;
                    end
                  end
                  REG: begin
                    rd_reg <= next_byte;
                    state  <= ACK_R;
                  end
                  default: begin
                    wr_reg   <= rd_reg;
                    wr_data  <= next_byte;
                    wr_valid <= 1'b1;
                    rd_reg   <= rd_reg + 8'd1;
                    state    <= ACK_D;
                  end
                endcase
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          // First falling edge starts the ACK pull-down, second ends it.
          ACK_A, ACK_R, ACK_D: begin
            if (fall) begin
              if (!ack_on) begin
                ack_on    <= 1'b1;
                drive_low <= 1'b1;
              end else begin
                ack_on    <= 1'b0;
                drive_low <= 1'b0;
                if (state == ACK_A && rw) begin
`ifdef SCCB_READ_EN
                  tx        <= regs.rd_data;
                  drive_low <= ~regs.rd_data[7];
                  state     <= RD_BYTE;
`else
                  state     <= WAIT_STOP;
`endif
                end else if (state == ACK_A) begin
                  state <= REG;
                end else begin
                  state <= DATA;
                end
              end
            end
          end
`ifdef SCCB_READ_EN
          // Bit 7 was placed on the edge that entered this state; each later
          // falling edge presents the next bit until 8 have been clocked.
          RD_BYTE: begin
            if (rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (fall) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt   <= '0;
                drive_low <= 1'b0;
                rd_acked  <= 1'b0;
                state     <= RD_ACK;
              end else begin
                drive_low <= ~tx[6];
                tx        <= {tx[6:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (rise) begin
              if (sd) begin
                state <= WAIT_STOP;
              end else begin
                rd_reg   <= rd_reg + 8'd1;
                rd_acked <= 1'b1;
              end
            end else if (fall && rd_acked) begin
              rd_acked  <= 1'b0;
              tx        <= regs.rd_data;
              drive_low <= ~regs.rd_data[7];
              state     <= RD_BYTE;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign siod          = drive_low ? 1'b0 : 1'bz;
  assign regs.wr_valid = wr_valid;
  assign regs.wr_reg   = wr_reg;
  assign regs.wr_data  = wr_data;
  assign regs.rd_reg   = rd_reg;
  assign regs.busy     = busy;

endmodule
